block_nest_checker: RTL

BLOCK_NEST_CHECKER -- requirements
Module: block_nest_checker

---
 rtl/block_chk_pkg.sv | 49 ++++
 rtl/block_nest_checker_if.sv | 25 ++
 rtl/block_char_class.sv | 19 +
 rtl/block_nest_checker.sv | 80 ++++++++
 4 files changed

// File: rtl/block_chk_pkg.sv
// Shared definitions for the begin/end nesting checker: word FSM encodings,
// ASCII constants and the per-letter keyword transition function.
package block_chk_pkg;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_B1    = 4'd1,
    ST_B2    = 4'd2,
    ST_B3    = 4'd3,
    ST_B4    = 4'd4,
    ST_B5    = 4'd5,
    ST_E1    = 4'd6,
    ST_E2    = 4'd7,
    ST_E3    = 4'd8,
    ST_OTHER = 4'd9
  } word_state_t;

  localparam logic [7:0] CH_A_LO = 8'h61;  // 'a'
  localparam logic [7:0] CH_Z_LO = 8'h7a;  // 'z'
  localparam logic [7:0] CH_A_UP = 8'h41;  // 'A'
  localparam logic [7:0] CH_Z_UP = 8'h5a;  // 'Z'
  localparam logic [7:0] CH_B    = 8'h62;
  localparam logic [7:0] CH_E    = 8'h65;
  localparam logic [7:0] CH_G    = 8'h67;
  localparam logic [7:0] CH_I    = 8'h69;
  localparam logic [7:0] CH_N    = 8'h6e;
  localparam logic [7:0] CH_D    = 8'h64;

  // Next word state when a letter arrives; any mismatch drops to OTHER.
  function automatic word_state_t letter_step(word_state_t s, logic [7:0] c);
    word_state_t r;
    r = ST_OTHER;
    case (s)
      ST_IDLE: begin
        if (c == CH_B)      r = ST_B1;
        else if (c == CH_E) r = ST_E1;
      end
      ST_B1: if (c == CH_E) r = ST_B2;
      ST_B2: if (c == CH_G) r = ST_B3;
      ST_B3: if (c == CH_I) r = ST_B4;
      ST_B4: if (c == CH_N) r = ST_B5;
      ST_E1: if (c == CH_N) r = ST_E2;
      ST_E2: if (c == CH_D) r = ST_E3;
      default: r = ST_OTHER;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/block_nest_checker_if.sv
// Character stream in, nesting status out. in_valid qualifies in on each
// rising clk edge; there is no backpressure, so every valid byte is consumed.
interface block_nest_checker_if
  import block_chk_pkg::*;
#(
  parameter int DEPTH_W = 8
);
  logic [7:0]         in;
  logic               in_valid;
  logic               result;
  logic [DEPTH_W-1:0] depth;
  logic               err_under;
  logic               err_over;
  word_state_t        fsm_state;

  modport master (
    output in, in_valid,
    input  result, depth, err_under, err_over, fsm_state
  );

  modport slave (
    input  in, in_valid,
    output result, depth, err_under, err_over, fsm_state
  );
endinterface

// File: rtl/block_char_class.sv
// Classifies a byte as letter/delimiter and optionally folds A-Z to a-z.
module block_char_class
  import block_chk_pkg::*;
#(
  parameter bit CASE_FOLD = 1'b1
) (
  input  logic [7:0] in,
  output logic       is_letter,
  output logic [7:0] folded
);
  logic is_lower;
  logic is_upper;

  assign is_lower  = (in >= CH_A_LO) && (in <= CH_Z_LO);
  assign is_upper  = (in >= CH_A_UP) && (in <= CH_Z_UP);
  assign is_letter = is_lower || is_upper;
  // Without folding, uppercase stays out of the a-z range and never matches.
  assign folded    = (CASE_FOLD && is_upper) ? (in | 8'h20) : in;
endmodule

// File: rtl/block_nest_checker.sv
// Tracks begin/end keyword nesting over an ASCII stream and reports whether
// the stream so far is balanced, counting a half-finished keyword as pending.
module block_nest_checker
  import block_chk_pkg::*;
#(
  parameter int DEPTH_W   = 8,
  parameter int MAX_DEPTH = 2**DEPTH_W-1,
  parameter bit CASE_FOLD = 1'b1
) (
  input logic                clk,
  input logic                reset,
  block_nest_checker_if.slave bus
);
  localparam logic [DEPTH_W-1:0] MAX_D = DEPTH_W'(MAX_DEPTH);

  word_state_t              state, state_nxt;
  logic [DEPTH_W-1:0]       depth_q, depth_nxt;
  logic                     eu_q, eu_nxt;
  logic                     eo_q, eo_nxt;
  logic                     is_letter;
  logic [7:0]               folded;
  logic signed [DEPTH_W+1:0] pending;
  logic signed [DEPTH_W+1:0] view;

  block_char_class #(.CASE_FOLD(CASE_FOLD)) u_class (
    .in        (bus.in),
    .is_letter (is_letter),
    .folded    (folded)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      depth_q <= '0;
      eu_q    <= 1'b0;
      eo_q    <= 1'b0;
    end else begin
      state   <= state_nxt;
      depth_q <= depth_nxt;
      eu_q    <= eu_nxt;
      eo_q    <= eo_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    depth_nxt = depth_q;
    eu_nxt    = eu_q;
    eo_nxt    = eo_q;
    if (bus.in_valid) begin
      if (is_letter) begin
        state_nxt = letter_step(state, folded);
      end else begin
        state_nxt = ST_IDLE;
        // A delimiter only commits a fully matched keyword.
        if (state == ST_B5) begin
          if (depth_q == MAX_D) eo_nxt = 1'b1;
          else                  depth_nxt = depth_q + DEPTH_W'(1);
        end else if (state == ST_E3) begin
          if (depth_q == '0) eu_nxt = 1'b1;
          else               depth_nxt = depth_q - DEPTH_W'(1);
        end
      end
    end
  end

  always_comb begin
    pending = '0;
    if (state == ST_B5)      pending = {{(DEPTH_W+1){1'b0}}, 1'b1};
    else if (state == ST_E3) pending = '1;
  end

  assign view = $signed({2'b00, depth_q}) + pending;

  assign bus.result    = !eu_q && !eo_q && (view == '0);
  assign bus.depth     = depth_q;
  assign bus.err_under = eu_q;
  assign bus.err_over  = eo_q;
  assign bus.fsm_state = state;
endmodule
